// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback arbiter.
// Holds the request payload struct, the source enum and the default sizes.
package wb_pkg;

  localparam int WB_REG_COUNT = 32;
  localparam int WB_REG_WIDTH = 32;
  localparam int AW           = $clog2(WB_REG_COUNT);

  // One writeback request: destination register and the value to write.
  typedef struct packed {
    logic [AW-1:0]           rd;
    logic [WB_REG_WIDTH-1:0] data;
  } wb_req_t;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_skid_buffer.sv
// One-entry request buffer placed in front of the writeback arbiter.
// Handshake: a request transfers on a clock edge where valid & ready; ready is
// high whenever the slot is empty or its current entry is being granted, so a
// fill and a drain in the same cycle sustain one request per cycle.
// Requests to register 0 are accepted and dropped without filling the slot.
// other_older marks that the other source's buffer holds an older entry; it is
// used to keep program order between writes to the same register.
module wb_skid_buffer
  import wb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    valid,
  output logic    ready,
  input  wb_req_t req,
  input  logic    granted,
  input  logic    other_full,
  input  logic    other_granted,
  output logic    full,
  output wb_req_t entry,
  output logic    other_older
);

  logic capture;

  assign ready   = !full | granted;
  assign capture = valid & ready & (req.rd != '0);

  // Slot fill/drain and the age relation to the other source's slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      full        <= 1'b0;
      entry       <= '0;
      other_older <= 1'b0;
    end else if (capture) begin
      full        <= 1'b1;
      entry       <= req;
      other_older <= other_full & !other_granted;
    end else begin
      if (granted) begin
        full <= 1'b0;
      end
      // Once the other entry has left, this one is the oldest in flight.
      if (other_granted) begin
        other_older <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter driving the register file write port (we3/ad3/wd3).
// Two producers (ALU, LSU) each feed a one-entry skid buffer; at most one
// buffered entry is granted per cycle and loaded into the registered write port.
// Same-register entries drain oldest first (LSU first on a same-cycle tie);
// different registers alternate round-robin.
// Optional feature macro: WB_SCOREBOARD_EN adds the per-register busy bits.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int  REG_COUNT = WB_REG_COUNT,
  parameter int  REG_WIDTH = WB_REG_WIDTH,
  localparam int ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ADDR_W-1:0]    alu_rd,
  input  logic [REG_WIDTH-1:0] alu_data,
  input  logic                 lsu_valid,
  output logic                 lsu_ready,
  input  logic [ADDR_W-1:0]    lsu_rd,
  input  logic [REG_WIDTH-1:0] lsu_data,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_rd,
  output logic [REG_COUNT-1:0] busy,
  output logic                 we3,
  output logic [ADDR_W-1:0]    ad3,
  output logic [REG_WIDTH-1:0] wd3
);

  wb_req_t alu_req, lsu_req, alu_entry, lsu_entry, gnt_req;
  logic    alu_full, lsu_full, alu_other_older, lsu_other_older;
  logic    gnt_alu, gnt_lsu, any_grant, rr_update;
  wb_src_e rr_ptr;

  assign alu_req.rd   = alu_rd;
  assign alu_req.data = alu_data;
  assign lsu_req.rd   = lsu_rd;
  assign lsu_req.data = lsu_data;

  wb_skid_buffer u_alu_buf (
    .clk           (clk),
    .rst           (rst),
    .valid         (alu_valid),
    .ready         (alu_ready),
    .req           (alu_req),
    .granted       (gnt_alu),
    .other_full    (lsu_full),
    .other_granted (gnt_lsu),
    .full          (alu_full),
    .entry         (alu_entry),
    .other_older   (alu_other_older)
  );

  wb_skid_buffer u_lsu_buf (
    .clk           (clk),
    .rst           (rst),
    .valid         (lsu_valid),
    .ready         (lsu_ready),
    .req           (lsu_req),
    .granted       (gnt_lsu),
    .other_full    (alu_full),
    .other_granted (gnt_alu),
    .full          (lsu_full),
    .entry         (lsu_entry),
    .other_older   (lsu_other_older)
  );

  // Grant selection from buffer state: age order for same rd, round-robin otherwise.
  always_comb begin
    gnt_alu   = 1'b0;
    gnt_lsu   = 1'b0;
    rr_update = 1'b0;
    if (alu_full && lsu_full) begin
      if (alu_entry.rd == lsu_entry.rd) begin
        if (alu_other_older) begin
          gnt_lsu = 1'b1;
        end else if (lsu_other_older) begin
          gnt_alu = 1'b1;
        end else begin
          gnt_lsu = 1'b1;
        end
      end else begin
        // Only contested different-rd decisions move the round-robin pointer.
        rr_update = 1'b1;
        if (rr_ptr == WB_SRC_LSU) begin
          gnt_alu = 1'b1;
        end else begin
          gnt_lsu = 1'b1;
        end
      end
    end else if (alu_full) begin
      gnt_alu = 1'b1;
    end else if (lsu_full) begin
      gnt_lsu = 1'b1;
    end
    any_grant = gnt_alu | gnt_lsu;
    gnt_req   = gnt_alu ? alu_entry : lsu_entry;
  end

  // Registered write port and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      we3    <= 1'b0;
      ad3    <= '0;
      wd3    <= '0;
      rr_ptr <= WB_SRC_LSU;
    end else begin
      we3 <= any_grant;
      if (any_grant) begin
        ad3 <= gnt_req.rd;
        wd3 <= gnt_req.data;
      end
      if (rr_update) begin
        rr_ptr <= gnt_alu ? WB_SRC_ALU : WB_SRC_LSU;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [REG_COUNT-1:0] busy_q, busy_next;

  // Pending-write bits: grant clears first, issue sets last so set wins.
  always_comb begin
    busy_next = busy_q;
    if (any_grant) begin
      busy_next[gnt_req.rd] = 1'b0;
    end
    if (issue_valid && issue_rd != '0) begin
      busy_next[issue_rd] = 1'b1;
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  assign busy = busy_q;
`else
  logic unused_issue;

  assign unused_issue = ^{issue_valid, issue_rd};
  assign busy         = '0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Testbench for writeback_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference model built from slot timestamps.
module tb_writeback_arbiter;

  localparam int AW = 5;
  localparam int W  = 32;
  localparam int RC = 32;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          alu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
  logic          alu_ready, lsu_ready, we3;
  logic [AW-1:0] alu_rd = '0, lsu_rd = '0, issue_rd = '0, ad3;
  logic [W-1:0]  alu_data = '0, lsu_data = '0, wd3;
  logic [RC-1:0] busy;

  writeback_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy        (busy),
    .we3         (we3),
    .ad3         (ad3),
    .wd3         (wd3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Sampled DUT values
  logic          s_alu_ready, s_lsu_ready, s_we3;
  logic [AW-1:0] s_ad3;
  logic [W-1:0]  s_wd3;
  logic [RC-1:0] s_busy;
  logic [W-1:0]  rf [RC];

  // Reference model: two slots with capture timestamps; index 0 = ALU, 1 = LSU
  bit            m_full [2];
  logic [AW-1:0] m_rd [2];
  logic [W-1:0]  m_data [2];
  int            m_ts [2];
  int            m_ptr;
  logic          m_we;
  logic [AW-1:0] m_ad;
  logic [W-1:0]  m_wd;
  logic [RC-1:0] m_busy;
  int            m_gnt;
  bit            m_rr;
  bit            e_ready [2];
  int            cyc;

  logic [AW+W-1:0] exp_q[$];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) m_full[i] = 0;
    m_ptr = 1; m_we = 0; m_ad = '0; m_wd = '0; m_busy = '0;
  endfunction

  function automatic void model_grant();
    m_gnt = -1;
    m_rr  = 0;
    if (m_full[0] && m_full[1]) begin
      if (m_rd[0] == m_rd[1]) m_gnt = (m_ts[0] < m_ts[1]) ? 0 : 1;
      else begin m_rr = 1; m_gnt = (m_ptr == 1) ? 0 : 1; end
    end else if (m_full[0]) m_gnt = 0;
    else if (m_full[1]) m_gnt = 1;
    for (int i = 0; i < 2; i++) e_ready[i] = !m_full[i] || (m_gnt == i);
  endfunction

  function automatic void model_edge(input logic r, input logic av, input logic [AW-1:0] ard,
                                     input logic [W-1:0] adat, input logic lv, input logic [AW-1:0] lrd,
                                     input logic [W-1:0] ldat, input logic iv, input logic [AW-1:0] ird);
    bit acc_a, acc_l;
    cyc++;
    if (r) begin model_reset(); return; end
    acc_a = av && e_ready[0] && ard != 0;
    acc_l = lv && e_ready[1] && lrd != 0;
    if (m_gnt >= 0) begin
      m_we = 1; m_ad = m_rd[m_gnt]; m_wd = m_data[m_gnt]; m_full[m_gnt] = 0;
`ifdef WB_SCOREBOARD_EN
      m_busy[m_ad] = 1'b0;
`endif
      if (m_rr) m_ptr = m_gnt;
    end else m_we = 0;
    if (acc_a) begin m_full[0] = 1; m_rd[0] = ard; m_data[0] = adat; m_ts[0] = cyc; end
    if (acc_l) begin m_full[1] = 1; m_rd[1] = lrd; m_data[1] = ldat; m_ts[1] = cyc; end
`ifdef WB_SCOREBOARD_EN
    if (iv && ird != 0) m_busy[ird] = 1'b1;
`endif
  endfunction

  // Driver: one clock cycle. Inputs change at negedge, readies sampled 1ns later,
  // outputs sampled 1ns after the posedge.
  task automatic cycle(input logic r, input logic av, input logic [AW-1:0] ard, input logic [W-1:0] adat,
                       input logic lv, input logic [AW-1:0] lrd, input logic [W-1:0] ldat,
                       input logic iv, input logic [AW-1:0] ird);
    @(negedge clk);
    rst = r; alu_valid = av; alu_rd = ard; alu_data = adat;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat; issue_valid = iv; issue_rd = ird;
    #1;
    s_alu_ready = alu_ready; s_lsu_ready = lsu_ready;
    model_grant();
    @(posedge clk);
    model_edge(r, av, ard, adat, lv, lrd, ldat, iv, ird);
    #1;
    s_we3 = we3; s_ad3 = ad3; s_wd3 = wd3; s_busy = busy;
    if (s_we3 === 1'b1) rf[s_ad3] = s_wd3;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, '0, '0, 0, '0);
  endtask

  task automatic test_reset();
    cycle(1, 1, 5'd5, 32'h1234_5678, 0, '0, '0, 0, '0);
    cycle(1, 1, 5'd5, 32'h1234_5678, 0, '0, '0, 0, '0);
    n_tests++; if (s_we3 !== 1'b0) begin n_fail++; $display("FAIL reset_we3: got %b expected 0", s_we3); end
    n_tests++; if (s_ad3 !== 5'd0) begin n_fail++; $display("FAIL reset_ad3: got %0d expected 0", s_ad3); end
    n_tests++; if (s_wd3 !== 32'd0) begin n_fail++; $display("FAIL reset_wd3: got %h expected 0", s_wd3); end
    n_tests++; if (s_busy !== '0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", s_busy); end
    idle(1);
    n_tests++; if (s_alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alu_ready: got %b expected 1", s_alu_ready); end
    n_tests++; if (s_we3 !== 1'b0) begin n_fail++; $display("FAIL reset_no_write0: got %b expected 0", s_we3); end
    idle(1);
    n_tests++; if (s_we3 !== 1'b0) begin n_fail++; $display("FAIL reset_no_write1: got %b expected 0", s_we3); end
  endtask

  task automatic test_single_alu();
    cycle(0, 1, 5'd5, 32'hDEAD_BEEF, 0, '0, '0, 0, '0);
    n_tests++; if (s_alu_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b expected 1", s_alu_ready); end
    n_tests++; if (s_we3 !== 1'b0) begin n_fail++; $display("FAIL single_early: got we3=%b expected 0", s_we3); end
    idle(1);
    n_tests++; if (s_we3 !== 1'b1 || s_ad3 !== 5'd5 || s_wd3 !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL single_write: got we3=%b ad3=%0d wd3=%h expected 1/5/deadbeef", s_we3, s_ad3, s_wd3); end
    idle(1);
    n_tests++; if (s_we3 !== 1'b0 || s_ad3 !== 5'd5) begin
      n_fail++; $display("FAIL single_once: got we3=%b ad3=%0d expected 0/5", s_we3, s_ad3); end
  endtask

  task automatic test_conflict_diff();
    cycle(1, 0, '0, '0, 0, '0, '0, 0, '0);
    cycle(0, 1, 5'd3, 32'h0000_0333, 1, 5'd4, 32'h0000_0444, 0, '0);
    idle(1);
    n_tests++; if (s_lsu_ready !== 1'b0) begin n_fail++; $display("FAIL diff_lsu_stall: got %b expected 0", s_lsu_ready); end
    n_tests++; if (s_we3 !== 1'b1 || s_ad3 !== 5'd3 || s_wd3 !== 32'h333) begin
      n_fail++; $display("FAIL diff_first: got we3=%b ad3=%0d wd3=%h expected 1/3/333", s_we3, s_ad3, s_wd3); end
    idle(1);
    n_tests++; if (s_lsu_ready !== 1'b1) begin n_fail++; $display("FAIL diff_lsu_release: got %b expected 1", s_lsu_ready); end
    n_tests++; if (s_we3 !== 1'b1 || s_ad3 !== 5'd4 || s_wd3 !== 32'h444) begin
      n_fail++; $display("FAIL diff_second: got we3=%b ad3=%0d wd3=%h expected 1/4/444", s_we3, s_ad3, s_wd3); end
    idle(1);
    n_tests++; if (s_we3 !== 1'b0) begin n_fail++; $display("FAIL diff_done: got we3=%b expected 0", s_we3); end
  endtask

  task automatic test_conflict_same();
    cycle(0, 1, 5'd7, 32'd1, 1, 5'd7, 32'd2, 0, '0);
    idle(1);
    n_tests++; if (s_alu_ready !== 1'b0) begin n_fail++; $display("FAIL same_alu_stall: got %b expected 0", s_alu_ready); end
    n_tests++; if (s_we3 !== 1'b1 || s_ad3 !== 5'd7 || s_wd3 !== 32'd2) begin
      n_fail++; $display("FAIL same_first: got we3=%b ad3=%0d wd3=%0d expected 1/7/2", s_we3, s_ad3, s_wd3); end
    idle(1);
    n_tests++; if (s_we3 !== 1'b1 || s_ad3 !== 5'd7 || s_wd3 !== 32'd1) begin
      n_fail++; $display("FAIL same_second: got we3=%b ad3=%0d wd3=%0d expected 1/7/1", s_we3, s_ad3, s_wd3); end
    idle(1);
    n_tests++; if (rf[7] !== 32'd1) begin n_fail++; $display("FAIL same_final: got %0d expected 1", rf[7]); end
  endtask

  task automatic test_x0_drop();
    cycle(0, 0, '0, '0, 1, 5'd0, 32'hFFFF_FFFF, 0, '0);
    n_tests++; if (s_lsu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b expected 1", s_lsu_ready); end
    for (int i = 0; i < 3; i++) begin
      idle(1);
      n_tests++; if (s_we3 !== 1'b0) begin n_fail++; $display("FAIL x0_no_write: got we3=%b ad3=%0d expected we3=0", s_we3, s_ad3); end
    end
  endtask

  task automatic test_scoreboard();
`ifdef WB_SCOREBOARD_EN
    cycle(0, 0, '0, '0, 0, '0, '0, 1, 5'd9);
    n_tests++; if (s_busy[9] !== 1'b1) begin n_fail++; $display("FAIL sb_set: got %b expected 1", s_busy[9]); end
    cycle(0, 1, 5'd9, 32'h99, 0, '0, '0, 0, '0);
    n_tests++; if (s_busy[9] !== 1'b1) begin n_fail++; $display("FAIL sb_hold: got %b expected 1", s_busy[9]); end
    idle(1);
    n_tests++; if (s_we3 !== 1'b1 || s_busy[9] !== 1'b0) begin
      n_fail++; $display("FAIL sb_clear: got we3=%b busy9=%b expected 1/0", s_we3, s_busy[9]); end
    cycle(0, 1, 5'd9, 32'hAA, 0, '0, '0, 0, '0);
    cycle(0, 0, '0, '0, 0, '0, '0, 1, 5'd9);
    n_tests++; if (s_we3 !== 1'b1 || s_busy[9] !== 1'b1) begin
      n_fail++; $display("FAIL sb_set_wins: got we3=%b busy9=%b expected 1/1", s_we3, s_busy[9]); end
    cycle(0, 0, '0, '0, 0, '0, '0, 1, 5'd0);
    n_tests++; if (s_busy !== 32'h0000_0200) begin n_fail++; $display("FAIL sb_x0: got %h expected 00000200", s_busy); end
`else
    cycle(0, 0, '0, '0, 0, '0, '0, 1, 5'd9);
    idle(1);
    n_tests++; if (s_busy !== '0) begin n_fail++; $display("FAIL sb_tied: got %h expected 0", s_busy); end
`endif
  endtask

  task automatic test_back_to_back();
    int writes = 0;
    logic [AW+W-1:0] exp_item;
    cycle(1, 0, '0, '0, 0, '0, '0, 0, '0);
    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] d = $urandom;
      if (i < 8) cycle(0, 1, AW'(i + 1), d, 0, '0, '0, 0, '0);
      else idle(1);
      if (i < 8) begin
        n_tests++; if (s_alu_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b expected 1", i, s_alu_ready); end
        exp_q.push_back({AW'(i + 1), d});
      end
      if (s_we3 === 1'b1) begin
        writes++;
        exp_item = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        n_tests++; if ({s_ad3, s_wd3} !== exp_item) begin
          n_fail++; $display("FAIL b2b_data: got %0d/%h expected %0d/%h", s_ad3, s_wd3, exp_item[AW+W-1:W], exp_item[W-1:0]); end
      end
    end
    n_tests++; if (writes != 8 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_count: got %0d writes, %0d left expected 8/0", writes, exp_q.size()); end
  endtask

  task automatic test_random();
    cycle(1, 0, '0, '0, 0, '0, '0, 0, '0);
    for (int i = 0; i < 500; i++) begin
      logic r = ($urandom_range(0, 79) == 0);
      logic av = $urandom_range(0, 1), lv = $urandom_range(0, 1), iv = ($urandom_range(0, 3) == 0);
      logic [AW-1:0] ard = AW'($urandom_range(0, 3)), lrd = AW'($urandom_range(0, 3)), ird = AW'($urandom_range(0, 3));
      logic [W-1:0] adat = $urandom, ldat = $urandom;
      cycle(r, av, ard, adat, lv, lrd, ldat, iv, ird);
      if (!r) begin
        n_tests++; if (s_alu_ready !== e_ready[0] || s_lsu_ready !== e_ready[1]) begin
          n_fail++; $display("FAIL rnd_ready@%0d: got alu=%b lsu=%b expected %b/%b", i, s_alu_ready, s_lsu_ready, e_ready[0], e_ready[1]); end
      end
      n_tests++; if (s_we3 !== m_we || s_ad3 !== m_ad || s_wd3 !== m_wd) begin
        n_fail++; $display("FAIL rnd_port@%0d: got %b/%0d/%h expected %b/%0d/%h", i, s_we3, s_ad3, s_wd3, m_we, m_ad, m_wd); end
      n_tests++; if (s_busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy@%0d: got %h expected %h", i, s_busy, m_busy); end
      if (s_we3 === 1'b1) begin
        n_tests++; if (s_ad3 === '0) begin n_fail++; $display("FAIL rnd_x0@%0d: got ad3=0 expected nonzero", i); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < RC; i++) rf[i] = '0;
    cyc = 0;
    model_reset();
    test_reset();
    test_single_alu();
    test_conflict_diff();
    test_conflict_same();
    test_x0_drop();
    test_scoreboard();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
